// File: rtl/gaussian_filter_accel_pkg.sv
// gaussian_filter_accel_pkg: shared multiplier widths, latency and helpers
package gaussian_filter_accel_pkg;
  localparam int MUL_DIN_W = 16;
  localparam int MUL_DOUT_W = 32;
  localparam int MUL_LAT = 3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/gaussian_filter_accel_mul_mul_16ns_16ns_32_4_1.sv
// gaussian_filter_accel_mul_mul_16ns_16ns_32_4_1: 3-stage ce-gated unsigned 16x16 multiplier
module gaussian_filter_accel_mul_mul_16ns_16ns_32_4_1
  import gaussian_filter_accel_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [MUL_DIN_W-1:0]  din0,
  input  logic [MUL_DIN_W-1:0]  din1,
  output logic [MUL_DOUT_W-1:0] dout
);
  logic [MUL_DIN_W-1:0] a_r, b_r;
  logic [MUL_DOUT_W-1:0] p_r;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
      p_r <= '0;
      dout <= '0;
    end else if (ce) begin
      a_r <= din0;
      b_r <= din1;
      p_r <= MUL_DOUT_W'(a_r) * MUL_DOUT_W'(b_r);
      dout <= p_r;
    end
endmodule

// File: rtl/gaussian_filter_accel_mul_arbiter.sv
// gaussian_filter_accel_mul_arbiter: round-robin sharing of one pipelined multiplier,
// with a tag pipeline that returns the requester id alongside each product.
module gaussian_filter_accel_mul_arbiter
  import gaussian_filter_accel_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [MUL_DIN_W*NUM_REQ-1:0]   req_a,
  input  logic [MUL_DIN_W*NUM_REQ-1:0]   req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [MUL_DOUT_W-1:0]          rsp_data,
  output logic                           idle
);
  logic [MUL_LAT-1:0] tag_v;
  logic [ID_W-1:0] tag_id [MUL_LAT];
  logic [ID_W-1:0] rr_ptr, gnt;
  logic gnt_v, stall, issue;
  logic [MUL_DIN_W-1:0] din0, din1;
  assign stall = rsp_valid & ~rsp_ready;
  // Scanning downward leaves the first valid requester at or after rr_ptr as the winner.
  always_comb begin
    int j;
    gnt_v = 1'b0;
    gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(rr_ptr) + i) % NUM_REQ;
      if (req_valid[j]) begin
        gnt_v = 1'b1;
        gnt = ID_W'(j);
      end
    end
  end
  assign issue = gnt_v & ~stall & ~reset;
  assign req_ready = issue ? NUM_REQ'(1) << gnt : '0;
  assign din0 = req_a[MUL_DIN_W*gnt +: MUL_DIN_W];
  assign din1 = req_b[MUL_DIN_W*gnt +: MUL_DIN_W];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tag_v <= '0;
      rr_ptr <= '0;
      for (int k = 0; k < MUL_LAT; k++) tag_id[k] <= '0;
    end else if (!stall) begin
      tag_v <= {tag_v[MUL_LAT-2:0], issue};
      tag_id[0] <= gnt;
      for (int k = 1; k < MUL_LAT; k++) tag_id[k] <= tag_id[k-1];
      if (issue) rr_ptr <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    end
  gaussian_filter_accel_mul_mul_16ns_16ns_32_4_1 u_mul (
    .clk(clk),
    .reset(reset),
    .ce(~stall),
    .din0(din0),
    .din1(din1),
    .dout(rsp_data)
  );
  assign rsp_valid = tag_v[MUL_LAT-1];
  assign rsp_id = tag_id[MUL_LAT-1];
  assign idle = ~|tag_v & ~|req_valid;
endmodule

// File: tb/tb_gaussian_filter_accel_mul_arbiter.sv
// tb_gaussian_filter_accel_mul_arbiter: directed and random stimulus against an
// in-order scoreboard where each op becomes visible after three unstalled edges.
module tb_gaussian_filter_accel_mul_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [16*N-1:0] req_a = '0;
  logic [16*N-1:0] req_b = '0;
  logic rsp_valid, idle;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [31:0] rsp_data;
  typedef struct {int id; logic [31:0] p; int age;} op_t;
  op_t q[$];
  int ptr = 0;
  int checks = 0;
  int failures = 0;
  int remaining [N];

  always #5 clk = ~clk;

  gaussian_filter_accel_mul_arbiter dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .idle(idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int i, input logic [15:0] a, input logic [15:0] b, input int n);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    remaining[i] = n;
    req_valid[i] = 1'b1;
  endtask

  // One clock: check outputs at the falling edge, then advance the model past the rising edge.
  task automatic cyc();
    logic [N-1:0] er;
    logic ev, stall, rs;
    logic [15:0] as, bs;
    int g;
    @(negedge clk);
    rs = reset;
    ev = !rs && q.size() > 0 && q[0].age >= 3;
    stall = ev && !rsp_ready;
    er = '0;
    g = -1;
    as = '0;
    bs = '0;
    if (!rs && !stall)
      for (int i = 0; i < N; i++)
        if (g < 0 && req_valid[(ptr + i) % N]) g = (ptr + i) % N;
    if (g >= 0) begin
      er[g] = 1'b1;
      as = req_a[16*g +: 16];
      bs = req_b[16*g +: 16];
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("idle", 64'(idle), 64'(q.size() == 0 && req_valid == '0));
    if (ev) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_data", 64'(rsp_data), 64'(q[0].p));
    end
    @(posedge clk);
    if (rs) return;
    if (!stall) begin
      if (ev) void'(q.pop_front());
      foreach (q[k]) q[k].age++;
      if (g >= 0) begin
        q.push_back('{id: g, p: 32'(as) * 32'(bs), age: 1});
        ptr = (g + 1) % N;
      end
    end
    #1;
    if (g >= 0) begin
      remaining[g]--;
      if (remaining[g] > 0) begin
        req_a[16*g +: 16] = 16'($urandom);
        req_b[16*g +: 16] = 16'($urandom);
      end else req_valid[g] = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || req_valid != '0) && k < 100) begin
      cyc();
      k++;
    end
    chk("drain_timeout", 64'(k < 100), 64'(1));
    cyc();
  endtask

  task automatic rst_pulse();
    #1 reset = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    q.delete();
    ptr = 0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    cyc();
    #2 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) remaining[i] = 0;
    cyc();
    cyc();
    #2 reset = 1'b0;
    req(0, 16'd3, 16'd5, 1);
    drain();
    rst_pulse();
    for (int i = 0; i < N; i++) req(i, 16'(i + 1), 16'(i + 2), 1);
    drain();
    req(0, 16'($urandom), 16'($urandom), 8);
    req(2, 16'($urandom), 16'($urandom), 8);
    drain();
    req(1, 16'hFFFF, 16'hFFFF, 1);
    drain();
    req(1, 16'h0000, 16'hFFFF, 1);
    drain();
    req(3, 16'($urandom), 16'($urandom), 6);
    cyc();
    cyc();
    cyc();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    rsp_ready = 1'b1;
    drain();
    req(0, 16'($urandom), 16'($urandom), 2);
    cyc();
    cyc();
    rst_pulse();
    cyc();
    req(1, 16'($urandom), 16'($urandom), 1);
    req(3, 16'($urandom), 16'($urandom), 1);
    drain();
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(3) == 0)
          req(i, 16'($urandom), 16'($urandom), int'($urandom_range(3, 1)));
      rsp_ready = $urandom_range(3) != 0;
      cyc();
    end
    rsp_ready = 1'b1;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
